// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipelined MIPS control unit: opcode/funct
// encodings, ALU operation encodings and the control bundle that travels
// down the pipe alongside each instruction.
package pipe_ctrl_pkg;

  // Opcodes recognised by the main decoder
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // aluop: how the ALU decoder should pick the operation
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // alucontrol encodings seen by the ALU
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regdst;
    logic [2:0] alucontrol;
  } ctrl_bundle_t;

  // A bubble is a fully inert bundle, valid bit included
  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

  // Everything the Decode stage produces for one instruction
  typedef struct packed {
    ctrl_bundle_t ctrl;
    logic         branch;
    logic         jump;
  } decode_t;

endpackage

// File: rtl/pipe_ctrl_gen_stage_reg.sv
// One pipeline register for the control bundle. Clear always wins over hold
// here; a stage that needs hold to dominate masks clear at the instantiation.
module ctrl_stage_reg
  import pipe_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         hold,
  input  logic         clear,
  input  ctrl_bundle_t d,
  output ctrl_bundle_t q
);

  // Bundle register: async reset, then clear-to-bubble, hold, or load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= CTRL_BUBBLE;
    end else if (clear) begin
      q <= CTRL_BUBBLE;
    end else if (hold) begin
      q <= q;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_ctrl_gen.sv
// Pipelined MIPS control unit. Decodes op/funct in Decode and carries the
// control bundle through Execute, MEM_STAGES Memory stages and Writeback.
// Optional feature macro: PIPE_CTRL_BNE_EN adds bne (branch on not equal).
module pipe_ctrl_gen
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_STAGES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            op,
  input  logic [5:0]            funct,
  input  logic                  equalD,
  input  logic                  stallE,
  input  logic                  flushE,
  input  logic                  flushM,
  output logic                  pcsrcD,
  output logic                  jumpD,
  output logic                  branchD,
  output logic                  alusrcE,
  output logic                  regdstE,
  output logic [2:0]            alucontrolE,
  output logic                  regwriteE,
  output logic                  memtoregE,
  output logic                  validE,
  output logic                  memwriteM,
  output logic [MEM_STAGES-1:0] regwriteM,
  output logic [MEM_STAGES-1:0] validM,
  output logic                  regwriteW,
  output logic                  memtoregW,
  output logic                  validW
);

  if (MEM_STAGES < 1 || MEM_STAGES > 4) begin : g_bad_depth
    $fatal(1, "pipe_ctrl_gen: MEM_STAGES must be in 1..4");
  end

  // ALU decoder: {recognised, alucontrol}. Unknown R-type funct is not recognised.
  function automatic logic [3:0] alu_decode(input logic [1:0] aluop, input logic [5:0] fn);
    logic [3:0] r;
    case (aluop)
      ALUOP_ADD: r = {1'b1, ALU_ADD};
      ALUOP_SUB: r = {1'b1, ALU_SUB};
      ALUOP_FUNCT: begin
        case (fn)
          FN_ADD:  r = {1'b1, ALU_ADD};
          FN_SUB:  r = {1'b1, ALU_SUB};
          FN_AND:  r = {1'b1, ALU_AND};
          FN_OR:   r = {1'b1, ALU_OR};
          FN_SLT:  r = {1'b1, ALU_SLT};
          default: r = {1'b0, ALU_ADD};
        endcase
      end
      default: r = {1'b1, ALU_ADD};
    endcase
    return r;
  endfunction

  // Main decoder; an unrecognised opcode yields an invalid bundle with ALU add
  function automatic decode_t decode(input logic [5:0] opc, input logic [5:0] fn);
    decode_t    r;
    logic [1:0] aluop;
    logic [3:0] alu;
    r     = '0;
    aluop = ALUOP_ADD;
    case (opc)
      OP_RTYPE: begin
        r.ctrl.valid    = 1'b1;
        r.ctrl.regwrite = 1'b1;
        r.ctrl.regdst   = 1'b1;
        aluop           = ALUOP_FUNCT;
      end
      OP_LW: begin
        r.ctrl.valid    = 1'b1;
        r.ctrl.regwrite = 1'b1;
        r.ctrl.alusrc   = 1'b1;
        r.ctrl.memtoreg = 1'b1;
      end
      OP_SW: begin
        r.ctrl.valid    = 1'b1;
        r.ctrl.alusrc   = 1'b1;
        r.ctrl.memwrite = 1'b1;
      end
      OP_BEQ: begin
        r.ctrl.valid = 1'b1;
        r.branch     = 1'b1;
        aluop        = ALUOP_SUB;
      end
      OP_BNE: begin
`ifdef PIPE_CTRL_BNE_EN
        r.ctrl.valid = 1'b1;
        r.branch     = 1'b1;
        aluop        = ALUOP_SUB;
`else
        r.ctrl.valid = 1'b0;
`endif
      end
      OP_ADDI: begin
        r.ctrl.valid    = 1'b1;
        r.ctrl.regwrite = 1'b1;
        r.ctrl.alusrc   = 1'b1;
      end
      // A jump is resolved in Decode and leaves nothing for later stages
      OP_J: r.jump = 1'b1;
      default: r.ctrl.valid = 1'b0;
    endcase
    alu               = alu_decode(aluop, fn);
    r.ctrl.alucontrol = alu[2:0];
    r.ctrl.regwrite   = r.ctrl.regwrite & alu[3];
    return r;
  endfunction

  decode_t      dec;
  ctrl_bundle_t e_q;
  ctrl_bundle_t m_q [MEM_STAGES];
  ctrl_bundle_t w_q;

  // Decode stage: purely combinational from op/funct
  always_comb begin
    dec = decode(op, funct);
  end

  // Branch resolution; bne inverts the register-compare sense
  always_comb begin
`ifdef PIPE_CTRL_BNE_EN
    if (op == OP_BNE) begin
      pcsrcD = dec.branch & ~equalD;
    end else begin
      pcsrcD = dec.branch & equalD;
    end
`else
    pcsrcD = dec.branch & equalD;
`endif
  end

  assign jumpD   = dec.jump;
  assign branchD = dec.branch;

  // Execute: a stall holds E and overrides any flush requested in the same cycle
  ctrl_stage_reg u_e (
    .clk   (clk),
    .rst   (reset),
    .hold  (stallE),
    .clear (flushE & ~stallE),
    .d     (dec.ctrl),
    .q     (e_q)
  );

  for (genvar i = 0; i < MEM_STAGES; i++) begin : g_mem
    if (i == 0) begin : g_first
      // M[0] takes a bubble while E is held or when explicitly flushed
      ctrl_stage_reg u_m (
        .clk   (clk),
        .rst   (reset),
        .hold  (1'b0),
        .clear (stallE | flushM),
        .d     (e_q),
        .q     (m_q[i])
      );
    end else begin : g_rest
      ctrl_stage_reg u_m (
        .clk   (clk),
        .rst   (reset),
        .hold  (1'b0),
        .clear (1'b0),
        .d     (m_q[i-1]),
        .q     (m_q[i])
      );
    end
    assign regwriteM[i] = m_q[i].regwrite;
    assign validM[i]    = m_q[i].valid;
    // Datapath fields are carried for completeness but only regwrite/valid leave
    logic unused_m;
    assign unused_m = ^m_q[i];
  end

  // Writeback register, never stalled
  ctrl_stage_reg u_w (
    .clk   (clk),
    .rst   (reset),
    .hold  (1'b0),
    .clear (1'b0),
    .d     (m_q[MEM_STAGES-1]),
    .q     (w_q)
  );

  assign alusrcE     = e_q.alusrc;
  assign regdstE     = e_q.regdst;
  assign alucontrolE = e_q.alucontrol;
  assign regwriteE   = e_q.regwrite;
  assign memtoregE   = e_q.memtoreg;
  assign validE      = e_q.valid;
  assign memwriteM   = m_q[0].memwrite;
  assign regwriteW   = w_q.regwrite;
  assign memtoregW   = w_q.memtoreg;
  assign validW      = w_q.valid;

  logic unused_ew;
  assign unused_ew = ^{e_q, w_q};

endmodule

// File: tb/tb_pipe_ctrl_gen.sv
// Self-checking bench for pipe_ctrl_gen: two instances (MEM_STAGES 1 and 3)
// share one directed stimulus stream; W-stage results go through a scoreboard.
module tb_pipe_ctrl_gen;

  localparam logic [5:0] NOP  = 6'b111111;
  localparam logic [5:0] RTY  = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] BNE  = 6'b000101;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] op, funct;
  logic equalD, stallE, flushE, flushM;

  logic pcsrcD_1, jumpD_1, branchD_1, alusrcE_1, regdstE_1, regwriteE_1, memtoregE_1, validE_1;
  logic [2:0] alucontrolE_1;
  logic memwriteM_1, regwriteW_1, memtoregW_1, validW_1;
  logic [0:0] regwriteM_1, validM_1;

  logic pcsrcD_3, jumpD_3, branchD_3, alusrcE_3, regdstE_3, regwriteE_3, memtoregE_3, validE_3;
  logic [2:0] alucontrolE_3;
  logic memwriteM_3, regwriteW_3, memtoregW_3, validW_3;
  logic [2:0] regwriteM_3, validM_3;

  pipe_ctrl_gen #(.MEM_STAGES(1)) u_ms1 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .equalD(equalD),
    .stallE(stallE), .flushE(flushE), .flushM(flushM),
    .pcsrcD(pcsrcD_1), .jumpD(jumpD_1), .branchD(branchD_1),
    .alusrcE(alusrcE_1), .regdstE(regdstE_1), .alucontrolE(alucontrolE_1),
    .regwriteE(regwriteE_1), .memtoregE(memtoregE_1), .validE(validE_1),
    .memwriteM(memwriteM_1), .regwriteM(regwriteM_1), .validM(validM_1),
    .regwriteW(regwriteW_1), .memtoregW(memtoregW_1), .validW(validW_1)
  );

  pipe_ctrl_gen #(.MEM_STAGES(3)) u_ms3 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .equalD(equalD),
    .stallE(stallE), .flushE(flushE), .flushM(flushM),
    .pcsrcD(pcsrcD_3), .jumpD(jumpD_3), .branchD(branchD_3),
    .alusrcE(alusrcE_3), .regdstE(regdstE_3), .alucontrolE(alucontrolE_3),
    .regwriteE(regwriteE_3), .memtoregE(memtoregE_3), .validE(validE_3),
    .memwriteM(memwriteM_3), .regwriteM(regwriteM_3), .validM(validM_3),
    .regwriteW(regwriteW_3), .memtoregW(memtoregW_3), .validW(validW_3)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   due;
    logic rw;
    logic mtr;
    logic v;
  } exp_t;

  exp_t sb1[$];
  exp_t sb3[$];
  int cyc = 0;
  int n_assert = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Expected W result for an instruction whose effective E-entry cycle is base
  task automatic push(input int base, input logic rw, input logic mtr, input logic v);
    sb1.push_back('{base + 2, rw, mtr, v});
    sb3.push_back('{base + 4, rw, mtr, v});
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (sb1.size() > 0 && sb1[0].due <= cyc) begin
      e = sb1.pop_front();
      chk("ms1_W_{valid,regwrite,memtoreg}", {29'd0, validW_1, regwriteW_1, memtoregW_1}, {29'd0, e.v, e.rw, e.mtr});
    end
    while (sb3.size() > 0 && sb3[0].due <= cyc) begin
      e = sb3.pop_front();
      chk("ms3_W_{valid,regwrite,memtoreg}", {29'd0, validW_3, regwriteW_3, memtoregW_3}, {29'd0, e.v, e.rw, e.mtr});
    end
  endtask

  task automatic drive(input logic [5:0] o, input logic [5:0] f, input logic eq,
                       input logic st, input logic fe, input logic fm);
    op = o; funct = f; equalD = eq; stallE = st; flushE = fe; flushM = fm;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      drive(NOP, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(NOP, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_validE", {31'd0, validE_1}, 32'd0);
    chk("rst_alucontrolE", {29'd0, alucontrolE_3}, 32'd0);
    chk("rst_validM3", {29'd0, validM_3}, 32'd0);
    chk("rst_regwriteW", {31'd0, regwriteW_3}, 32'd0);
    chk("rst_memwriteM", {31'd0, memwriteM_1}, 32'd0);
    reset = 1'b0;

    // add: decode, E fields, W after MEM_STAGES+1
    drive(RTY, F_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("add_pcsrcD", {31'd0, pcsrcD_1}, 32'd0);
    chk("add_jumpD", {31'd0, jumpD_1}, 32'd0);
    push(cyc + 1, 1'b1, 1'b0, 1'b1);
    tick();
    chk("add_alucontrolE", {29'd0, alucontrolE_1}, 32'h2);
    chk("add_regdstE", {31'd0, regdstE_1}, 32'd1);
    chk("add_regwriteE", {31'd0, regwriteE_1}, 32'd1);
    chk("add_validE", {31'd0, validE_1}, 32'd1);
    chk("add_alusrcE", {31'd0, alusrcE_1}, 32'd0);
    drive(NOP, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("add_validM1", {31'd0, validM_1}, 32'd1);
    chk("add_regwriteM1", {31'd0, regwriteM_1}, 32'd1);
    chk("nop_validE", {31'd0, validE_1}, 32'd0);
    chk("add_validM3", {29'd0, validM_3}, 32'h1);
    tick();
    chk("add_validM3_shift", {29'd0, validM_3}, 32'h2);
    drain(4);

    // lw then sw back-to-back
    drive(LW, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(cyc + 1, 1'b1, 1'b1, 1'b1);
    tick();
    chk("lw_memtoregE", {31'd0, memtoregE_3}, 32'd1);
    chk("lw_alusrcE", {31'd0, alusrcE_3}, 32'd1);
    chk("lw_regdstE", {31'd0, regdstE_3}, 32'd0);
    drive(SW, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(cyc + 1, 1'b0, 1'b0, 1'b1);
    tick();
    chk("lw_in_M0_memwriteM", {31'd0, memwriteM_3}, 32'd0);
    chk("lw_regwriteM3", {29'd0, regwriteM_3}, 32'h1);
    drive(NOP, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("sw_in_M0_memwriteM3", {31'd0, memwriteM_3}, 32'd1);
    chk("sw_in_M0_memwriteM1", {31'd0, memwriteM_1}, 32'd1);
    chk("sw_regwriteM3", {29'd0, regwriteM_3}, 32'h2);
    chk("sw_validM3", {29'd0, validM_3}, 32'h3);
    tick();
    chk("sw_left_M0_memwriteM3", {31'd0, memwriteM_3}, 32'd0);
    drain(4);

    // beq taken/not taken, then j
    drive(BEQ, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("beq_eq1_pcsrcD", {31'd0, pcsrcD_1}, 32'd1);
    chk("beq_branchD", {31'd0, branchD_1}, 32'd1);
    equalD = 1'b0;
    #1;
    chk("beq_eq0_pcsrcD", {31'd0, pcsrcD_3}, 32'd0);
    push(cyc + 1, 1'b0, 1'b0, 1'b1);
    tick();
    chk("beq_alucontrolE", {29'd0, alucontrolE_1}, 32'h6);
    chk("beq_regwriteE", {31'd0, regwriteE_1}, 32'd0);
    drive(JMP, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("j_jumpD", {31'd0, jumpD_1}, 32'd1);
    chk("j_branchD", {31'd0, branchD_1}, 32'd0);
    push(cyc + 1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("j_validE", {31'd0, validE_1}, 32'd0);
    drain(2);

    // bne decode depends on build configuration
    drive(BNE, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
`ifdef PIPE_CTRL_BNE_EN
    chk("bne_eq0_pcsrcD", {31'd0, pcsrcD_1}, 32'd1);
    chk("bne_branchD", {31'd0, branchD_1}, 32'd1);
`else
    chk("bne_eq0_pcsrcD", {31'd0, pcsrcD_1}, 32'd0);
    chk("bne_branchD", {31'd0, branchD_1}, 32'd0);
`endif
    equalD = 1'b1;
    #1;
    chk("bne_eq1_pcsrcD", {31'd0, pcsrcD_3}, 32'd0);
    drive(NOP, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // stall with sub in E, then stall+flushE, then flushM
    drive(RTY, F_SUB, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("sub_alucontrolE", {29'd0, alucontrolE_3}, 32'h6);
    push(cyc + 2, 1'b1, 1'b0, 1'b1);
    drive(ADDI, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("stall1_alucontrolE", {29'd0, alucontrolE_3}, 32'h6);
    chk("stall1_validE", {31'd0, validE_3}, 32'd1);
    chk("stall1_validM3", {29'd0, validM_3}, 32'h0);
    chk("stall1_validM1", {31'd0, validM_1}, 32'd0);
    flushE = 1'b1;
    tick();
    chk("stall_flush_alucontrolE", {29'd0, alucontrolE_1}, 32'h6);
    chk("stall_flush_validE", {31'd0, validE_1}, 32'd1);
    chk("stall_flush_validM1", {31'd0, validM_1}, 32'd0);
    drive(ADDI, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(cyc + 1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("addi_alucontrolE", {29'd0, alucontrolE_1}, 32'h2);
    chk("addi_alusrcE", {31'd0, alusrcE_1}, 32'd1);
    chk("sub_released_validM1", {31'd0, validM_1}, 32'd1);
    chk("sub_released_regwriteM1", {31'd0, regwriteM_1}, 32'd1);
    drive(NOP, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk("flushM_validM1", {31'd0, validM_1}, 32'd0);
    chk("flushM_validM3", {29'd0, validM_3}, 32'h2);
    drain(4);

    // flushE kills lw in D; or in E proceeds into M[0]
    drive(RTY, F_OR, 1'b0, 1'b0, 1'b0, 1'b0);
    push(cyc + 1, 1'b1, 1'b0, 1'b1);
    tick();
    chk("or_alucontrolE", {29'd0, alucontrolE_3}, 32'h1);
    drive(LW, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("flushE_validE", {31'd0, validE_1}, 32'd0);
    chk("flushE_memtoregE", {31'd0, memtoregE_1}, 32'd0);
    chk("or_validM1", {31'd0, validM_1}, 32'd1);
    chk("or_regwriteM1", {31'd0, regwriteM_1}, 32'd1);
    drive(RTY, F_SLT, 1'b0, 1'b0, 1'b0, 1'b0);
    push(cyc + 1, 1'b1, 1'b0, 1'b1);
    tick();
    chk("slt_alucontrolE", {29'd0, alucontrolE_3}, 32'h7);
    drive(RTY, F_AND, 1'b0, 1'b0, 1'b0, 1'b0);
    push(cyc + 1, 1'b1, 1'b0, 1'b1);
    tick();
    chk("and_alucontrolE", {29'd0, alucontrolE_3}, 32'h0);
    drive(RTY, 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("badfn_regwriteE", {31'd0, regwriteE_3}, 32'd0);
    chk("badfn_alucontrolE", {29'd0, alucontrolE_3}, 32'h2);
    drain(5);

    // reset with four instructions in flight
    drive(RTY, F_ADD, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(LW, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(ADDI, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(RTY, F_SUB, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("inflight_validM3", {29'd0, validM_3}, 32'h7);
    drive(NOP, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("midrst_validE", {31'd0, validE_3}, 32'd0);
    chk("midrst_alucontrolE", {29'd0, alucontrolE_3}, 32'd0);
    chk("midrst_validM3", {29'd0, validM_3}, 32'h0);
    chk("midrst_regwriteM3", {29'd0, regwriteM_3}, 32'h0);
    chk("midrst_validM1", {31'd0, validM_1}, 32'd0);
    chk("midrst_regwriteW1", {31'd0, regwriteW_1}, 32'd0);
    tick();
    chk("held_rst_validE", {31'd0, validE_1}, 32'd0);
    reset = 1'b0;
    drive(ADDI, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(cyc + 1, 1'b1, 1'b0, 1'b1);
    tick();
    chk("post_rst_validE", {31'd0, validE_1}, 32'd1);
    chk("post_rst_alusrcE", {31'd0, alusrcE_3}, 32'd1);
    drain(5);

    chk("scoreboard_empty", sb1.size() + sb3.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
